// File: rtl/div_unit_pkg.sv
// Shared types and helpers for the EX-stage radix-2 restoring divider.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic [5:0] DIV_STEPS = 6'd32;

    // Magnitude of a two's complement value; 0x80000000 maps to itself and is read as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] value, input logic is_signed);
        return (is_signed && value[31]) ? (32'd0 - value) : value;
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] value, input logic negate);
        return negate ? (32'd0 - value) : value;
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring iteration: trial-subtract the divisor from the partial remainder, shift in a quotient bit.
module div_unit_step (
    input  logic [64:0] work_i,
    input  logic [31:0] divisor_i,
    output logic [64:0] work_o
);

    logic        fits;
    logic [31:0] trial;

    // The remainder after a successful subtract is below the divisor, so 32 bits of the difference suffice.
    always_comb begin
        fits   = work_i[64:32] >= {1'b0, divisor_i};
        trial  = work_i[63:32] - divisor_i;
        work_o = fits ? {trial, work_i[31:0], 1'b1} : {work_i[63:0], 1'b0};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit DIV/DIVU unit with EX-stage stall request.
// Define DIV_FAST_ZERO_EN to short-circuit a zero divisor through DIVZERO (2-cycle, result 0).
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    div_state_e  state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] op1_abs;
    logic [31:0] op2_abs;
    logic [64:0] step_work;

    assign op1_abs = abs32(opdata1_i, signed_div_i);
    assign op2_abs = abs32(opdata2_i, signed_div_i);

    div_unit_step u_step (
        .work_i    (work_q),
        .divisor_i (divisor_q),
        .work_o    (step_work)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            DIV_FREE: begin
                result_d = 64'd0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    divisor_d  = op2_abs;
                    neg_quot_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                    neg_rem_d  = signed_div_i && opdata1_i[31];
                    count_d    = 6'd0;
                    work_d     = {32'd0, op1_abs, 1'b0};
`ifdef DIV_FAST_ZERO_EN
                    state_d    = (op2_abs == 32'd0) ? DIV_BY_ZERO : DIV_ON;
`else
                    state_d    = DIV_ON;
`endif
                end
            end

            DIV_BY_ZERO: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    result_d = 64'd0;
                    ready_d  = 1'b1;
                    state_d  = DIV_END;
                end
            end

            // After the 32nd step the extra cycle applies sign correction and publishes the result.
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else if (count_q == DIV_STEPS) begin
                    result_d = {neg_if(work_q[64:33], neg_rem_q), neg_if(work_q[31:0], neg_quot_q)};
                    ready_d  = 1'b1;
                    state_d  = DIV_END;
                end else begin
                    work_d  = step_work;
                    count_d = count_q + 6'd1;
                end
            end

            DIV_END: begin
                if (!start_i) begin
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                    state_d  = DIV_FREE;
                end
            end

            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_FREE;
            count_q    <= 6'd0;
            work_q     <= 65'd0;
            divisor_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit against a magnitude/sign arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int total = 0;
    int bad   = 0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    // Reference: divide magnitudes, then give the quotient the XOR sign and the remainder the dividend sign.
    function automatic logic [63:0] model_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        bit          na, nb;
        na = sgn && a[31];
        nb = sgn && b[31];
        ma = na ? 32'd0 - a : a;
        mb = nb ? 32'd0 - b : b;
        if (mb == 32'd0) begin
`ifdef DIV_FAST_ZERO_EN
            return 64'd0;
`else
            q = 32'hFFFF_FFFF;
            r = ma;
`endif
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (na ^ nb) q = 32'd0 - q;
        if (na)      r = 32'd0 - r;
        return {r, q};
    endfunction

    function automatic int model_latency(input logic [31:0] b);
`ifdef DIV_FAST_ZERO_EN
        if (b == 32'd0) return 2;
`endif
        return 34;
    endfunction

    // Starts a division in the next cycle and waits (bounded) for ready_o; lat is -1 on timeout.
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit release_start,
                           output logic [63:0] res, output int lat, output int stall_cnt);
        @(posedge clk); #1;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        #1;
        stall_cnt = stallreq_o ? 1 : 0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (ready_o) begin
                lat = k;
                break;
            end
            if (stallreq_o) stall_cnt++;
        end
        res = result_o;
        if (release_start) begin
            start_i = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b0;
        annul_i = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (result_o !== 64'd0 || ready_o !== 1'b0 || stallreq_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got res=%h rdy=%b stall=%b want 0/0/0", result_o, ready_o, stallreq_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_divu_basic();
        logic [63:0] res; int lat, stall;
        run_div(1'b0, 32'd100, 32'd7, 1'b1, res, lat, stall);
        total++;
        if (lat !== 34) begin bad++; $display("[TB] FAIL divu_latency got %0d want 34", lat); end
        total++;
        if (stall !== 34) begin bad++; $display("[TB] FAIL divu_stall_cycles got %0d want 34", stall); end
        total++;
        if (res !== {32'd2, 32'd14}) begin bad++; $display("[TB] FAIL divu_100_7 got %h want %h", res, {32'd2, 32'd14}); end
    endtask

    task automatic test_div_signed();
        logic [63:0] res; int lat, stall;
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1, res, lat, stall);
        total++;
        if (res !== {32'hFFFF_FFFE, 32'hFFFF_FFF2}) begin
            bad++; $display("[TB] FAIL div_neg100_7 got %h want fffffffefffffff2", res);
        end
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat, stall);
        total++;
        if (res !== {32'd0, 32'h8000_0000}) begin
            bad++; $display("[TB] FAIL div_intmin_m1 got %h want 0000000080000000", res);
        end
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat, stall);
        total++;
        if (res !== {32'h8000_0000, 32'd0}) begin
            bad++; $display("[TB] FAIL divu_big got %h want 8000000000000000", res);
        end
    endtask

    task automatic test_div_zero();
        logic [63:0] res; int lat, stall;
        run_div(1'b0, 32'd5, 32'd0, 1'b1, res, lat, stall);
        total++;
`ifdef DIV_FAST_ZERO_EN
        if (lat !== 2 || res !== 64'd0) begin
            bad++; $display("[TB] FAIL divu_zero got lat=%0d res=%h want lat=2 res=0", lat, res);
        end
`else
        if (lat !== 34 || res !== {32'd5, 32'hFFFF_FFFF}) begin
            bad++; $display("[TB] FAIL divu_zero got lat=%0d res=%h want lat=34 res=00000005ffffffff", lat, res);
        end
`endif
    endtask

    task automatic test_annul();
        logic [63:0] res; int lat, stall;
        bool_seen: begin end
        @(posedge clk); #1;
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (ready_o) lat++;
        end
        total++;
        if (lat !== 0) begin bad++; $display("[TB] FAIL annul_no_ready got %0d ready cycles want 0", lat); end
        run_div(1'b0, 32'd1000, 32'd3, 1'b1, res, lat, stall);
        total++;
        if (res !== {32'd1, 32'd333} || lat !== 34) begin
            bad++; $display("[TB] FAIL annul_restart got res=%h lat=%0d want 000000010000014d lat=34", res, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res; int lat, stall;
        @(posedge clk); #1;
        signed_div_i = 1'b0;
        opdata1_i = 32'd77;
        opdata2_i = 32'd5;
        start_i = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        rst = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        total++;
        if (result_o !== 64'd0 || ready_o !== 1'b0 || stallreq_o !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_mid got res=%h rdy=%b stall=%b want 0/0/0", result_o, ready_o, stallreq_o);
        end
        rst = 1'b0;
        run_div(1'b0, 32'd77, 32'd5, 1'b1, res, lat, stall);
        total++;
        if (res !== {32'd2, 32'd15} || lat !== 34) begin
            bad++; $display("[TB] FAIL reset_mid_restart got res=%h lat=%0d want 000000020000000f lat=34", res, lat);
        end
        // Reset while a finished result is being held must also clear it.
        run_div(1'b0, 32'd77, 32'd5, 1'b0, res, lat, stall);
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (result_o !== 64'd0 || ready_o !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_in_end got res=%h rdy=%b want 0/0", result_o, ready_o);
        end
        rst = 1'b0;
        start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_hold_after_ready();
        logic [63:0] res; int lat, stall;
        run_div(1'b0, 32'd1234567, 32'd89, 1'b0, res, lat, stall);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (result_o !== model_div(1'b0, 32'd1234567, 32'd89) || ready_o !== 1'b1 || stallreq_o !== 1'b0) begin
                bad++; $display("[TB] FAIL hold_%0d got res=%h rdy=%b stall=%b", k, result_o, ready_o, stallreq_o);
            end
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        #1;
        total++;
        if (ready_o !== 1'b1) begin bad++; $display("[TB] FAIL hold_drop_same_cycle got rdy=%b want 1", ready_o); end
        @(posedge clk); #1;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            bad++; $display("[TB] FAIL hold_drop got rdy=%b res=%h want 0/0", ready_o, result_o);
        end
    endtask

    // Pick operands biased toward the edge values that stress sign handling.
    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd1;
            3: return $urandom_range(0, 255);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [63:0] res; int lat, stall;
        logic [31:0] a, b; bit sgn;
        for (int n = 0; n < 24; n++) begin
            sgn = $urandom_range(0, 1) == 1;
            a = pick_operand();
            b = pick_operand();
            if (n == 23) b = 32'd0;
            run_div(sgn, a, b, 1'b1, res, lat, stall);
            total++;
            if (res !== model_div(sgn, a, b) || lat !== model_latency(b) || stall !== lat) begin
                bad++;
                $display("[TB] FAIL random_%0d s=%0b a=%h b=%h got res=%h lat=%0d stall=%0d want res=%h lat=%0d",
                         n, sgn, a, b, res, lat, stall, model_div(sgn, a, b), model_latency(b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_div_signed();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_hold_after_ready();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
